// File: rtl/reg_writeback_queue.sv
// Write-back queue in front of the register file's r3 write port.
// Results are queued in order, issued one per cycle when the register file
// is not stalled, and searched by two bypass ports so operand fetch can see
// values that have not yet been written.
module reg_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_rd,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     rf_stall,
  output logic                     rf_read,
  output logic [ADDR_W-1:0]        rf_r3,
  output logic [DATA_W-1:0]        rf_r3_value,
  input  logic [ADDR_W-1:0]        q1_addr,
  input  logic [ADDR_W-1:0]        q2_addr,
  output logic                     q1_hit,
  output logic                     q2_hit,
  output logic [DATA_W-1:0]        q1_data,
  output logic [DATA_W-1:0]        q2_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wp_reg;
  logic [PTR_W-1:0]  rp_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic              push;
  logic              pop;
  logic [DEPTH-1:0]  entry_valid;
  logic [DEPTH-1:0]  q1_match;
  logic [DEPTH-1:0]  q2_match;

  // r0 results complete the handshake but are never stored.
  assign in_ready    = (count_reg < CNT_W'(DEPTH));
  assign push        = in_valid && in_ready && (in_rd != '0);
  assign pop         = (count_reg != '0) && !rf_stall;
  assign rf_read     = !pop;
  assign rf_r3       = rd_mem[rp_reg];
  assign rf_r3_value = data_mem[rp_reg];
  assign count       = count_reg;

  // Occupancy update; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_reg    <= '0;
      rp_reg    <= '0;
      count_reg <= '0;
    end else begin
      if (push) wp_reg <= wp_reg + 1'b1;
      if (pop)  rp_reg <= rp_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // Entry storage; cleared on reset so the head outputs read zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else if (push) begin
      rd_mem[wp_reg]   <= in_rd;
      data_mem[wp_reg] <= in_data;
    end
  end

  // An entry is live when its distance from the head is below the occupancy;
  // the head entry stays live during the cycle it is being popped.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PTR_W-1:0] age;
      assign age             = PTR_W'(gi) - rp_reg;
      assign entry_valid[gi] = ({1'b0, age} < count_reg);
      assign q1_match[gi]    = entry_valid[gi] && (rd_mem[gi] == q1_addr);
      assign q2_match[gi]    = entry_valid[gi] && (rd_mem[gi] == q2_addr);
    end
  endgenerate

  // Bypass select: walk from oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    q1_hit  = 1'b0;
    q2_hit  = 1'b0;
    q1_data = '0;
    q2_data = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rp_reg + PTR_W'(k);
      if (q1_match[idx] && (q1_addr != '0)) begin
        q1_hit  = 1'b1;
        q1_data = data_mem[idx];
      end
      if (q2_match[idx] && (q2_addr != '0)) begin
        q2_hit  = 1'b1;
        q2_data = data_mem[idx];
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Scoreboard bench for reg_writeback_queue: the stimulus side queues the
// expected register-file writes, a negedge monitor retires them as they issue.
module tb_reg_writeback_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rd = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              rf_stall = 1'b0;
  logic              rf_read;
  logic [ADDR_W-1:0] rf_r3;
  logic [DATA_W-1:0] rf_r3_value;
  logic [ADDR_W-1:0] q1_addr = '0;
  logic [ADDR_W-1:0] q2_addr = '0;
  logic              q1_hit;
  logic              q2_hit;
  logic [DATA_W-1:0] q1_data;
  logic [DATA_W-1:0] q2_data;
  logic [2:0]        count;

  wr_t exp_q[$];
  int  pass_cnt  = 0;
  int  total_cnt = 0;

  reg_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
    .rf_stall(rf_stall), .rf_read(rf_read), .rf_r3(rf_r3), .rf_r3_value(rf_r3_value),
    .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_hit(q1_hit), .q2_hit(q2_hit),
    .q1_data(q1_data), .q2_data(q2_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one result, waiting a bounded number of cycles for in_ready.
  task automatic send(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] data);
    int waited = 0;
    in_valid = 1'b1;
    in_rd    = rd;
    in_data  = data;
    #1;
    while (!in_ready && waited < 50) begin
      step();
      waited++;
    end
    chk("accept_ready", 32'(in_ready), 1);
    if (rd != '0) exp_q.push_back('{rd: rd, data: data});
    $display("send  rd=%0d data=%h", rd, data);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (count != '0 && n < 20) begin
      step();
      n++;
    end
    chk("drain_count", 32'(count), 0);
  endtask

  // Monitor: every issued write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && !rf_read) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_write: got rd=%0d data=%h expected no write", rf_r3, rf_r3_value);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        $display("write rd=%0d data=%h", rf_r3, rf_r3_value);
        chk("write_rd", 32'(rf_r3), 32'(e.rd));
        chk("write_data", rf_r3_value, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state.
    #2;
    chk("rst_rf_read", 32'(rf_read), 1);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_r3", 32'(rf_r3), 0);
    chk("rst_r3_value", rf_r3_value, 0);
    chk("rst_q1_hit", 32'(q1_hit), 0);
    step(); step();
    rst_n = 1'b1;

    // Single write, then bypass visibility at the head.
    send(5'd5, 32'hDEADBEEF);
    q1_addr = 5'd5;
    #1;
    chk("single_count", 32'(count), 1);
    chk("single_rf_read", 32'(rf_read), 0);
    chk("single_q1_hit", 32'(q1_hit), 1);
    chk("single_q1_data", q1_data, 32'hDEADBEEF);
    step();
    chk("single_after_count", 32'(count), 0);
    chk("single_after_rf_read", 32'(rf_read), 1);
    chk("single_after_q1_hit", 32'(q1_hit), 0);

    // Fill under stall, fifth result held off until space opens.
    rf_stall = 1'b1;
    for (int i = 1; i <= 4; i++) send(5'(i), 32'h100 + 32'(i));
    q1_addr = 5'd3;
    #1;
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_q1_hit", 32'(q1_hit), 1);
    chk("full_q1_data", q1_data, 32'h103);
    in_valid = 1'b1; in_rd = 5'd5; in_data = 32'h105;
    step();
    chk("full_hold_count", 32'(count), 4);
    chk("full_hold_ready", 32'(in_ready), 0);
    chk("full_hold_rf_read", 32'(rf_read), 1);
    rf_stall = 1'b0;
    send(5'd5, 32'h105);
    wait_drain();

    // r0 discard.
    send(5'd0, 32'h1234);
    q1_addr = 5'd0;
    #1;
    chk("r0_count", 32'(count), 0);
    chk("r0_in_ready", 32'(in_ready), 1);
    chk("r0_rf_read", 32'(rf_read), 1);
    chk("r0_q1_hit", 32'(q1_hit), 0);
    chk("r0_q1_data", q1_data, 0);

    // Bypass returns the youngest match; popping entry still hits.
    rf_stall = 1'b1;
    send(5'd7, 32'h11);
    send(5'd7, 32'h22);
    q1_addr = 5'd7; q2_addr = 5'd8;
    #1;
    chk("byp_q1_hit", 32'(q1_hit), 1);
    chk("byp_q1_data", q1_data, 32'h22);
    chk("byp_q2_hit", 32'(q2_hit), 0);
    chk("byp_q2_data", q2_data, 0);
    rf_stall = 1'b0;
    step();
    chk("byp_pop_count", 32'(count), 1);
    chk("byp_pop_q1_hit", 32'(q1_hit), 1);
    chk("byp_pop_q1_data", q1_data, 32'h22);
    step();
    chk("byp_done_q1_hit", 32'(q1_hit), 0);
    chk("byp_done_q1_data", q1_data, 0);

    // Streaming at one per cycle with pointer wrap.
    for (int i = 0; i < 12; i++) begin
      send(5'(i + 1), 32'hA000_0000 + 32'(i));
      chk("stream_count", 32'(count), 1);
    end
    wait_drain();

    // Reset mid-operation drops queued results.
    rf_stall = 1'b1;
    send(5'd9, 32'h99);
    send(5'd10, 32'hAA);
    send(5'd11, 32'hBB);
    q1_addr = 5'd9; q2_addr = 5'd11;
    #1;
    chk("pre_rst_count", 32'(count), 3);
    chk("pre_rst_q1_hit", 32'(q1_hit), 1);
    rst_n = 1'b0;
    rf_stall = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_rf_read", 32'(rf_read), 1);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_q1_hit", 32'(q1_hit), 0);
    chk("mid_rst_q2_hit", 32'(q2_hit), 0);
    chk("mid_rst_q1_data", q1_data, 0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("post_rst_count", 32'(count), 0);
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
